// File: rtl/ibert_stream_pkg.sv
// Shared types and defaults for the FIFO drain-side stream reader.
package ibert_stream_pkg;

    localparam int DEF_D_W   = 32;
    localparam int DEF_LEN_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream, bundled for the reader.
interface fifo_stream_reader_if #(
    parameter int D_W = 32
);

    logic                  fifo_read;
    logic                  fifo_empty;
    logic signed [D_W-1:0] fifo_data;

    logic                  m_valid;
    logic                  m_ready;
    logic signed [D_W-1:0] m_data;
    logic                  m_last;

    modport master (
        output fifo_read,
        input  fifo_empty,
        input  fifo_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        input  fifo_read,
        output fifo_empty,
        output fifo_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer; cnt is exported so the producer can meter credits.
module stream_skid_buf #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   cnt
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic         pop;

    assign out_valid = (cnt != 2'd0);
    assign out_data  = head;
    assign pop       = out_valid & out_ready;

    // NOTE: storage is in the reset branch so a mid-transfer reset leaves no stale word at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= in_data;
                    else             tail <= in_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a programmed number of words from a registered-output FIFO and
// re-emits them as a valid/ready stream with a last flag on the final word.
module fifo_stream_reader
    import ibert_stream_pkg::*;
#(
    parameter int D_W   = DEF_D_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    fifo_stream_reader_if.master io,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     words_sent
);

    rd_state_t        state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] received;
    logic             inflight;
    logic [1:0]       buf_cnt;
    logic [2:0]       occupancy;
    logic             pop;
    logic             cap_last;
    logic [D_W:0]     head_word;

    assign pop       = io.m_valid & io.m_ready;
    // Words already held or arriving next edge, minus the one leaving this edge.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign io.fifo_read = (state == RUN) && !io.fifo_empty
                          && (issued < len_r) && (occupancy < 3'd2);

    assign cap_last  = (received == len_r - LEN_W'(1));
    assign busy      = (state != IDLE);
    assign io.m_data = head_word[D_W-1:0];
    assign io.m_last = head_word[D_W];

    stream_skid_buf #(
        .W(D_W + 1)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight),
        .in_data  ({cap_last, io.fifo_data}),
        .out_ready(io.m_ready),
        .out_valid(io.m_valid),
        .out_data (head_word),
        .cnt      (buf_cnt)
    );

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_r      <= '0;
            issued     <= '0;
            received   <= '0;
            words_sent <= '0;
            inflight   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= io.fifo_read;
            if (io.fifo_read) issued     <= issued + LEN_W'(1);
            if (inflight)     received   <= received + LEN_W'(1);
            if (pop)          words_sent <= words_sent + LEN_W'(1);

            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len_r      <= len;
                            issued     <= '0;
                            received   <= '0;
                            words_sent <= '0;
                            state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issued == len_r) state <= DRAIN;
                end
                DRAIN: begin
                    // Only the word tagged len-1 carries last, so this is the final handshake.
                    if (pop && io.m_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural FIFO feeding the reader, scoreboard on the stream side.
module tb_fifo_stream_reader;
    import ibert_stream_pkg::*;

    localparam int D_W   = 32;
    localparam int LEN_W = 16;

    typedef struct {
        logic signed [D_W-1:0] data;
        logic                  last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_sent;

    fifo_stream_reader_if #(.D_W(D_W)) io ();

    fifo_stream_reader #(
        .D_W  (D_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .io        (io),
        .busy      (busy),
        .done      (done),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO with one-cycle registered read data.
    logic signed [D_W-1:0] fmem [0:255];
    logic [7:0] wr_ptr    = 8'd0;
    logic [7:0] rd_ptr    = 8'd0;
    logic       underflow = 1'b0;

    assign io.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (io.fifo_read) begin
            if (wr_ptr == rd_ptr) underflow <= 1'b1;
            io.fifo_data <= fmem[rd_ptr];
            rd_ptr       <= rd_ptr + 8'd1;
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc, reads, first_read, last_read, first_valid, valids, got, dones, done_cyc, last_hs, max_cnt;
    int rdy_mode = 0;
    logic                  prev_stall;
    logic signed [D_W-1:0] prev_data;
    logic                  prev_last;
    logic                  pulse_start = 1'b0;
    logic [LEN_W-1:0]      pulse_len   = '0;
    exp_t                  sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fifo_push(input int v);
        fmem[wr_ptr] = D_W'(v);
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic fifo_reload(input int n);
        wr_ptr = rd_ptr;
        for (int k = 1; k <= n; k++) fifo_push(k);
    endtask

    task automatic clear_stats();
        cyc = 0; reads = 0; first_read = -1; last_read = -1; first_valid = -1;
        valids = 0; got = 0; dones = 0; done_cyc = -1; last_hs = -1; max_cnt = 0;
        prev_stall = 1'b0;
    endtask

    task automatic start_xfer(input int n);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        len   = LEN_W'(n);
        clear_stats();
        for (int k = 1; k <= n; k++) begin
            e.data = D_W'(k);
            e.last = (k == n);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        start = pulse_start;
        if (pulse_start) len = pulse_len;
        pulse_start = 1'b0;
        case (rdy_mode)
            0:       io.m_ready = 1'b1;
            1:       io.m_ready = (cyc % 3 == 0);
            default: io.m_ready = 1'b0;
        endcase
        #1;
        if (io.fifo_read) begin
            reads++;
            if (first_read < 0) first_read = cyc;
            last_read = cyc;
        end
        if (io.m_valid) begin
            valids++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (int'(dut.u_buf.cnt) > max_cnt) max_cnt = int'(dut.u_buf.cnt);
        if (prev_stall) begin
            check("stall_valid", io.m_valid, 1'b1);
            check("stall_data", io.m_data, prev_data);
            check("stall_last", io.m_last, prev_last);
        end
        if (io.m_valid && io.m_ready) begin
            check("word_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("m_data", io.m_data, e.data);
                check("m_last", io.m_last, e.last);
            end
            got++;
            last_hs = cyc;
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        prev_stall = io.m_valid && !io.m_ready;
        prev_data  = io.m_data;
        prev_last  = io.m_last;
        cyc++;
    endtask

    task automatic run_until_done(input int budget);
        while (dones == 0 && cyc < budget) step();
        check("done_within_budget", dones != 0, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_fifo_read"}, io.fifo_read, 1'b0);
        check({tag, "_m_valid"}, io.m_valid, 1'b0);
        check({tag, "_m_data"}, io.m_data, '0);
        check({tag, "_m_last"}, io.m_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_words_sent"}, words_sent, '0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        io.m_ready = 1'b0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // 1: len=8, free-flowing stream
        fifo_reload(8);
        rdy_mode = 0;
        start_xfer(8);
        run_until_done(40);
        step(); step();
        check("t1_first_read", first_read, 0);
        check("t1_last_read", last_read, 7);
        check("t1_reads", reads, 8);
        check("t1_first_valid", first_valid, 2);
        check("t1_last_handshake", last_hs, 9);
        check("t1_done_cycle", done_cyc, 10);
        check("t1_done_pulses", dones, 1);
        check("t1_words", got, 8);
        check("t1_words_sent", words_sent, 8);
        check("t1_busy_after", busy, 1'b0);
        check("t1_sb_empty", sb.size(), 0);

        // 2: shorter transfer leaves the rest in the FIFO
        fifo_reload(8);
        start_xfer(5);
        run_until_done(40);
        step(); step();
        check("t2_reads", reads, 5);
        check("t2_words", got, 5);
        check("t2_fifo_left", 8'(wr_ptr - rd_ptr), 3);
        check("t2_fifo_not_empty", io.fifo_empty, 1'b0);
        check("t2_words_sent", words_sent, 5);

        // 3: back-pressure 1,0,0 pattern
        fifo_reload(6);
        rdy_mode = 1;
        start_xfer(6);
        run_until_done(80);
        check("t3_words", got, 6);
        check("t3_reads", reads, 6);
        check("t3_max_buf_ok", max_cnt <= 2, 1'b1);
        check("t3_sb_empty", sb.size(), 0);

        // 4: FIFO runs dry mid-transfer, refilled later
        fifo_reload(2);
        rdy_mode = 0;
        start_xfer(4);
        repeat (10) step();
        check("t4_paused_words", got, 2);
        check("t4_paused_busy", busy, 1'b1);
        check("t4_paused_valid", io.m_valid, 1'b0);
        fifo_push(3);
        fifo_push(4);
        run_until_done(40);
        check("t4_words", got, 4);
        check("t4_no_bubbles", valids, 4);
        check("t4_words_sent", words_sent, 4);

        // 5a: zero-length transfer
        start_xfer(0);
        repeat (3) step();
        check("t5_zero_done", dones, 1);
        check("t5_zero_done_cycle", done_cyc, 0);
        check("t5_zero_reads", reads, 0);
        check("t5_zero_valids", valids, 0);

        // 5b: start during RUN is ignored
        fifo_reload(8);
        start_xfer(4);
        step(); step();
        pulse_start = 1'b1;
        pulse_len   = LEN_W'(7);
        run_until_done(40);
        step(); step();
        check("t5_restart_reads", reads, 4);
        check("t5_restart_words", got, 4);
        check("t5_restart_words_sent", words_sent, 4);
        check("t5_restart_done_pulses", dones, 1);

        // 6: asynchronous reset with two words buffered
        fifo_reload(8);
        rdy_mode = 2;
        start_xfer(8);
        repeat (6) step();
        check("t6_buf_full", dut.u_buf.cnt, 2'd2);
        check("t6_valid_before", io.m_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        fifo_reload(3);
        rdy_mode = 0;
        start_xfer(3);
        run_until_done(30);
        check("t6_words", got, 3);
        check("t6_words_sent", words_sent, 3);
        check("t6_sb_empty", sb.size(), 0);

        check("fifo_no_underflow", underflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
